pixel_stream_source: RTL and testbench

Frame-buffer reader that produces the raster pixel stream consumed by the separable Gaussian blur stage of the SIFT pipeline. On a start pulse it reads one WIDTH×HEIGHT 8-bit frame from a synchronous-read frame memory in raster order. It then appends a run of zero pixels so the blur's line buffers drain. Output is valid/ready; the blur's clock enable is driven as Pix_valid & Pix_ready.

---
 rtl/sift_pkg.sv | 29 ++
 rtl/pix_skid_fifo.sv | 59 +++++
 rtl/pixel_stream_source.sv | 171 +++++++++++++++++
 tb/tb_pixel_stream_source.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT pixel pipeline: default image size,
// reader FSM encoding, and the pixel-plus-sideband bundle carried between stages.
package sift_pkg;

   localparam int IMG_WIDTH  = 400;
   localparam int IMG_HEIGHT = 300;
   localparam int PIX_W      = 8;
   localparam int BUNDLE_W   = PIX_W + 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   typedef struct packed {
      logic             flush;
      logic             eol;
      logic             sof;
      logic [PIX_W-1:0] pix;
   } pix_bundle_t;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry first-word-fall-through FIFO for pixel bundles; the head entry is a
// register so the consumer sees stable data while it holds off.
module pix_skid_fifo
   import sift_pkg::*;
#(
   parameter int DATA_W = BUNDLE_W
) (
   input  logic              i_clk,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_tail;
   logic [1:0]        r_count;
   logic              w_push;
   logic              w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         // NOTE: the two entries are cleared too, so the registered outputs read 0 after reset.
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_data;
               else                 r_tail <= i_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_head <= i_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_data  = r_head;
   assign o_count = r_count;

endmodule

// File: rtl/pixel_stream_source.sv
// Raster frame-buffer reader feeding the Gaussian blur: streams WIDTHxHEIGHT pixels
// from a synchronous-read memory, then FLUSH_COUNT zero pixels to drain line buffers.
module pixel_stream_source
   import sift_pkg::*;
#(
   parameter int WIDTH       = IMG_WIDTH,
   parameter int HEIGHT      = IMG_HEIGHT,
   parameter int FLUSH_COUNT = 2*WIDTH+2,
   parameter int ADDR_W      = 17
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic              Busy,
   output logic              Done,
   output logic              Mem_rd,
   output logic [ADDR_W-1:0] Mem_addr,
   input  logic [7:0]        Mem_data,
   output logic [7:0]        Pix_out,
   output logic              Pix_valid,
   input  logic              Pix_ready,
   output logic              Pix_sof,
   output logic              Pix_eol,
   output logic              Pix_flush
);

   localparam int COL_W  = cnt_width(WIDTH);
   localparam int ROW_W  = cnt_width(HEIGHT);
   localparam int FCNT_W = cnt_width(FLUSH_COUNT + 1);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = (FLUSH_COUNT > 0) ? FCNT_W'(FLUSH_COUNT - 1) : '0;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [COL_W-1:0]    r_col;
   logic [ROW_W-1:0]    r_row;
   logic [FCNT_W-1:0]   r_fcnt;
   logic                r_inflight;
   logic                r_if_sof;
   logic                r_if_eol;
   logic                r_if_flush;

   logic                w_issue_rd;
   logic                w_issue_zero;
   logic                w_done;
   logic                w_xfer;
   logic                w_room;
   logic                w_first;
   logic                w_eol;
   logic                w_last_pix;
   logic [1:0]          w_fifo_count;
   pix_bundle_t         w_push_bundle;
   pix_bundle_t         w_head;

   assign w_xfer     = Pix_valid && Pix_ready;
   assign w_first    = (r_row == '0) && (r_col == '0);
   assign w_eol      = (r_col == COL_LAST);
   assign w_last_pix = w_eol && (r_row == ROW_LAST);

   // Issue only if the pixel can land without overflowing the FIFO: the transfer
   // happening this cycle frees a slot, so Mem_rd depends on Pix_ready combinationally.
   assign w_room = (({1'b0, w_fifo_count} + {2'b00, r_inflight}) - {2'b00, w_xfer}) < 3'd2;

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_next = r_state;
      w_issue_rd   = 1'b0;
      w_issue_zero = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Start) w_state_next = ST_READ;
         end
         ST_READ: begin
            if (w_room) begin
               w_issue_rd = 1'b1;
               if (w_last_pix) w_state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (FLUSH_COUNT == 0) begin
               w_state_next = ST_DRAIN;
            end else if (w_room) begin
               w_issue_zero = 1'b1;
               if (r_fcnt == FCNT_LAST) w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((w_fifo_count == 2'd0) && !r_inflight) begin
               w_done       = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_addr     <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_fcnt     <= '0;
         r_inflight <= 1'b0;
         r_if_sof   <= 1'b0;
         r_if_eol   <= 1'b0;
         r_if_flush <= 1'b0;
      end else begin
         r_inflight <= w_issue_rd || w_issue_zero;
         r_if_sof   <= w_issue_rd && w_first;
         r_if_eol   <= w_issue_rd && w_eol;
         r_if_flush <= w_issue_zero;
         if ((r_state == ST_IDLE) && Start) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
            r_fcnt <= '0;
         end else begin
            if (w_issue_rd) begin
               r_addr <= r_addr + ADDR_W'(1);
               if (w_eol) begin
                  r_col <= '0;
                  r_row <= r_row + ROW_W'(1);
               end else begin
                  r_col <= r_col + COL_W'(1);
               end
            end
            if (w_issue_zero) r_fcnt <= r_fcnt + FCNT_W'(1);
         end
      end
   end

   // Zero pixels travel the same one-cycle path as reads so ordering is uniform.
   always_comb begin
      w_push_bundle.flush = r_if_flush;
      w_push_bundle.eol   = r_if_eol;
      w_push_bundle.sof   = r_if_sof;
      w_push_bundle.pix   = r_if_flush ? 8'h00 : Mem_data;
   end

   pix_skid_fifo #(
      .DATA_W (BUNDLE_W)
   ) u_fifo (
      .i_clk   (Clk),
      .i_clear (Reset),
      .i_push  (r_inflight),
      .i_data  (w_push_bundle),
      .i_pop   (w_xfer),
      .o_data  (w_head),
      .o_count (w_fifo_count)
   );

   assign Pix_valid = (w_fifo_count != 2'd0);
   assign Pix_out   = w_head.pix;
   assign Pix_sof   = w_head.sof;
   assign Pix_eol   = w_head.eol;
   assign Pix_flush = w_head.flush;
   assign Mem_rd    = w_issue_rd;
   assign Mem_addr  = r_addr;
   assign Busy      = (r_state != ST_IDLE);
   assign Done      = w_done;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Self-checking bench for pixel_stream_source: a 4x3 frame with 10 flush pixels
// plus a 1x1 frame with no flush, against a transfer-level reference model.
module tb_pixel_stream_source;

   localparam int W      = 4;
   localparam int H      = 3;
   localparam int FC     = 10;
   localparam int N      = W * H;
   localparam int AW     = 17;
   localparam int T1_LEN = 27;

   typedef struct packed {
      logic       flush;
      logic       eol;
      logic       sof;
      logic [7:0] pix;
   } xfer_t;

   typedef struct {
      logic          ready;
      logic          busy;
      logic          mem_rd;
      logic [AW-1:0] addr;
      logic          valid;
      xfer_t         bundle;
      logic          done;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic          ready = 1'b0;
   logic          busy, done, mem_rd, valid, sof, eol, flush;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data = 8'h00;
   logic [7:0]    pix;

   logic          start2 = 1'b0;
   logic          s_busy, s_done, s_mem_rd, s_valid, s_sof, s_eol, s_flush;
   logic [AW-1:0] s_mem_addr;
   logic [7:0]    s_mem_data = 8'h00;
   logic [7:0]    s_pix;

   pixel_stream_source #(.WIDTH(W), .HEIGHT(H), .FLUSH_COUNT(FC), .ADDR_W(AW)) dut (
      .Clk(clk), .Reset(rst), .Start(start), .Busy(busy), .Done(done),
      .Mem_rd(mem_rd), .Mem_addr(mem_addr), .Mem_data(mem_data),
      .Pix_out(pix), .Pix_valid(valid), .Pix_ready(ready),
      .Pix_sof(sof), .Pix_eol(eol), .Pix_flush(flush)
   );

   pixel_stream_source #(.WIDTH(1), .HEIGHT(1), .FLUSH_COUNT(0), .ADDR_W(AW)) dut_small (
      .Clk(clk), .Reset(rst), .Start(start2), .Busy(s_busy), .Done(s_done),
      .Mem_rd(s_mem_rd), .Mem_addr(s_mem_addr), .Mem_data(s_mem_data),
      .Pix_out(s_pix), .Pix_valid(s_valid), .Pix_ready(1'b1),
      .Pix_sof(s_sof), .Pix_eol(s_eol), .Pix_flush(s_flush)
   );

   // Synchronous-read frame memories: data is valid the cycle after the strobe.
   logic [7:0] mem [N];
   always @(posedge clk) begin
      if (mem_rd) mem_data <= (int'(mem_addr) < N) ? mem[int'(mem_addr)] : 8'hEE;
      if (s_mem_rd) s_mem_data <= s_mem_addr[7:0];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the expected transfer sequence, consumed by the monitor.
   xfer_t exp_q[$];
   xfer_t cur_b;
   xfer_t prev_b;
   xfer_t mon_e;
   bit    mon_en    = 1'b0;
   bit    prev_hold = 1'b0;
   int    issued    = 0;
   int    xfers     = 0;

   assign cur_b = {flush, eol, sof, pix};

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_hold) check("hold_stable", 32'({valid, cur_b}), 32'({1'b1, prev_b}));
         if (mem_rd) begin
            check("rd_room", 32'((issued - xfers - int'(valid && ready)) < 2), 32'd1);
            check("rd_addr", 32'(mem_addr), 32'(issued));
         end
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               check("xfer_count", 32'(xfers + 1), 32'(N + FC));
            end else begin
               mon_e = exp_q.pop_front();
               check("xfer", 32'(cur_b), 32'(mon_e));
            end
            xfers++;
         end
         if (mem_rd) issued++;
         prev_hold = valid && !ready;
         prev_b    = cur_b;
      end
   end

   task automatic fill_mem_addr();
      for (int i = 0; i < N; i++) mem[i] = 8'(i);
   endtask

   // Builds the expected stream from the frame rules, then pulses Start so that
   // it is sampled at edge k; returns one tick after edge k (cycle k+1).
   task automatic start_frame();
      exp_q.delete();
      for (int i = 0; i < N; i++)
         exp_q.push_back('{flush: 1'b0, eol: ((i % W) == W - 1), sof: (i == 0), pix: mem[i]});
      for (int i = 0; i < FC; i++)
         exp_q.push_back('{flush: 1'b1, eol: 1'b0, sof: 1'b0, pix: 8'h00});
      issued    = 0;
      xfers     = 0;
      prev_hold = 1'b0;
      mon_en    = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         @(negedge clk);
         got = done;
         @(posedge clk); #1;
      end
      check(name, 32'(got), 32'd1);
      check({name, "_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   vec_t vec [T1_LEN + 1];
   bit   seen;
   bit   stalled;
   int   low_left;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int t = 1; t <= T1_LEN; t++) begin
         vec[t].ready  = 1'b1;
         vec[t].busy   = (t <= 3 + N + FC);
         vec[t].mem_rd = (t <= N);
         vec[t].addr   = AW'(t - 1);
         vec[t].valid  = (t >= 3) && (t < 3 + N + FC);
         vec[t].bundle = (t - 3 < N) ? {1'b0, (((t - 3) % W) == W - 1), (t == 3), 8'(t - 3)}
                                     : {1'b1, 1'b0, 1'b0, 8'h00};
         vec[t].done   = (t == 3 + N + FC);
      end
      fill_mem_addr();

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", 32'({busy, done, mem_rd, valid, sof, eol, flush}), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_pix", 32'(pix), 32'd0);
      check("rst_small", 32'({s_busy, s_done, s_mem_rd, s_valid, s_pix}), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // 1x1 frame, no flush: one pixel with sof and eol, Done at k+4.
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         check("s_busy", 32'(s_busy), 32'(t <= 4));
         check("s_rd", 32'(s_mem_rd), 32'(t == 1));
         if (t == 1) check("s_addr", 32'(s_mem_addr), 32'd0);
         check("s_valid", 32'(s_valid), 32'(t == 3));
         if (t == 3) check("s_pixel", 32'({s_flush, s_eol, s_sof, s_pix}), 32'({3'b011, 8'h00}));
         check("s_done", 32'(s_done), 32'(t == 4));
         @(posedge clk); #1;
      end

      // Table-driven full frame with Pix_ready held high.
      ready = 1'b1;
      start_frame();
      for (int t = 1; t <= T1_LEN; t++) begin
         ready = vec[t].ready;
         @(negedge clk);
         check("t1_busy", 32'(busy), 32'(vec[t].busy));
         check("t1_rd", 32'(mem_rd), 32'(vec[t].mem_rd));
         if (vec[t].mem_rd) check("t1_addr", 32'(mem_addr), 32'(vec[t].addr));
         check("t1_valid", 32'(valid), 32'(vec[t].valid));
         if (vec[t].valid) check("t1_pixel", 32'(cur_b), 32'(vec[t].bundle));
         check("t1_done", 32'(done), 32'(vec[t].done));
         @(posedge clk); #1;
      end
      check("t1_left", 32'(exp_q.size()), 32'd0);

      // Random 50% Pix_ready with random frame contents.
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      start_frame();
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         seen = done;
         @(posedge clk); #1;
      end
      check("rand_done", 32'(seen), 32'd1);
      check("rand_left", 32'(exp_q.size()), 32'd0);
      fill_mem_addr();

      // Five-cycle stall while pixel 5 is presented and pixel 6 is in flight.
      ready = 1'b1;
      start_frame();
      seen = 1'b0; stalled = 1'b0; low_left = 0;
      for (int c = 0; c < 80 && !seen; c++) begin
         if (!stalled && valid && (pix == 8'd5) && !flush) begin
            stalled  = 1'b1;
            low_left = 5;
         end
         ready = (low_left == 0);
         @(negedge clk);
         if (low_left > 0) begin
            check("stall_hold", 32'({valid, pix}), 32'({1'b1, 8'd5}));
            check("stall_no_rd", 32'(mem_rd), 32'd0);
            low_left--;
         end
         seen = done;
         @(posedge clk); #1;
      end
      check("stall_seen", 32'(stalled), 32'd1);
      check("stall_done", 32'(seen), 32'd1);
      check("stall_left", 32'(exp_q.size()), 32'd0);

      // Start re-pulsed mid-frame and in the Done cycle: both ignored.
      ready = 1'b1;
      start_frame();
      seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         start = (c == 6) || done;
         @(negedge clk);
         seen = done;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("repulse_done", 32'(seen), 32'd1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("repulse_idle", 32'({busy, valid, mem_rd}), 32'd0);
         @(posedge clk); #1;
      end
      check("repulse_left", 32'(exp_q.size()), 32'd0);

      // Reset at pixel 7, then restart from address 0.
      start_frame();
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (valid && (pix == 8'd7) && !flush) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      check("rst7_reached", 32'(seen), 32'd1);
      mon_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst7_after", 32'({valid, busy, mem_rd, done}), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst7_quiet", 32'({valid, busy, mem_rd}), 32'd0);
      end
      @(posedge clk); #1;
      start_frame();
      wait_done("rst7_restart", 60);
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
